// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the operand register bank and its read pipeline.
package reg_bank_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REGS   = 4;
    localparam int DEF_PIPE_DEPTH = 2;

    // A single-register bank still needs a one-bit address port.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic in_range(input int unsigned addr, input int unsigned n);
        return addr < n;
    endfunction

endpackage

// File: rtl/reg_bank_pipe_stage.sv
// One valid/data slot of the read pipeline; accepts when empty or when downstream drains.
module pipe_stage
    import reg_bank_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  up_valid,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic                  down_accept,
    input  logic                  flush,
    output logic                  up_accept,
    output logic                  v,
    output logic [DATA_WIDTH-1:0] data
);

    assign up_accept = !v || down_accept;

    // Data only moves with a valid token so an idle output keeps its last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v    <= 1'b0;
            data <= '0;
        end else begin
            if (flush) begin
                v <= 1'b0;
            end else if (up_accept) begin
                v <= up_valid;
            end
            if (up_accept && up_valid && !flush) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/reg_bank_pipe.sv
// Addressable operand register bank with write-first read bypass feeding a
// bubble-collapsing read pipeline with valid/ready output and flush.
module reg_bank_pipe
    import reg_bank_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              load,
    input  logic [addr_w(NUM_REGS)-1:0]       load_addr,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic                              rd_valid,
    input  logic [addr_w(NUM_REGS)-1:0]       rd_addr,
    output logic                              rd_ready,
    input  logic                              flush,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(PIPE_DEPTH + 1);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  load_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_data;

    logic [PIPE_DEPTH-1:0] stg_v;
    logic [DATA_WIDTH-1:0] stg_data [PIPE_DEPTH];

    assign load_ok = in_range(32'(load_addr), NUM_REGS);
    assign rd_ok   = in_range(32'(rd_addr), NUM_REGS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (load && load_ok) begin
            regs[load_addr] <= data_in;
        end
    end

    // Write-first: a same-cycle write to the read address is visible to the read.
    always_comb begin
        rd_data = '0;
        if (rd_ok) begin
            if (load && (load_addr == rd_addr)) begin
                rd_data = data_in;
            end else begin
                rd_data = regs[rd_addr];
            end
        end
    end

    // Each stage keeps its own accept net so the ready chain is a plain ripple.
    for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
        logic                  acc;
        logic                  up_v;
        logic [DATA_WIDTH-1:0] up_d;
        logic                  dn_acc;

        if (i == 0) begin : g_first
            assign up_v = rd_valid;
            assign up_d = rd_data;
        end else begin : g_next
            assign up_v = stg_v[i-1];
            assign up_d = stg_data[i-1];
        end

        if (i == PIPE_DEPTH - 1) begin : g_last
            assign dn_acc = out_ready;
        end else begin : g_inner
            assign dn_acc = g_stage[i+1].acc;
        end

        pipe_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk         (clk),
            .reset       (reset),
            .up_valid    (up_v),
            .up_data     (up_d),
            .down_accept (dn_acc),
            .flush       (flush),
            .up_accept   (acc),
            .v           (stg_v[i]),
            .data        (stg_data[i])
        );
    end

    assign rd_ready  = g_stage[0].acc && !flush;
    assign data_out  = stg_data[PIPE_DEPTH-1];
    assign out_valid = stg_v[PIPE_DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(stg_v[i]);
        end
    end

endmodule

// File: tb/tb_reg_bank_pipe.sv
// Scoreboard bench: default bank (4 regs, depth 2) plus a 3-reg, depth-4 instance.
module tb_reg_bank_pipe;
    import reg_bank_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        load_a, rd_valid_a, rd_ready_a, flush_a, out_valid_a, out_ready_a;
    logic [1:0]  load_addr_a, rd_addr_a, occupancy_a;
    logic [31:0] data_in_a, data_out_a;

    logic        load_b, rd_valid_b, rd_ready_b, flush_b, out_valid_b, out_ready_b;
    logic [1:0]  load_addr_b, rd_addr_b;
    logic [2:0]  occupancy_b;
    logic [31:0] data_in_b, data_out_b;

    reg_bank_pipe u_dut_a (
        .clk(clk), .reset(reset), .load(load_a), .load_addr(load_addr_a), .data_in(data_in_a),
        .rd_valid(rd_valid_a), .rd_addr(rd_addr_a), .rd_ready(rd_ready_a), .flush(flush_a),
        .data_out(data_out_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .occupancy(occupancy_a)
    );

    reg_bank_pipe #(.DATA_WIDTH(32), .NUM_REGS(3), .PIPE_DEPTH(4)) u_dut_b (
        .clk(clk), .reset(reset), .load(load_b), .load_addr(load_addr_b), .data_in(data_in_b),
        .rd_valid(rd_valid_b), .rd_addr(rd_addr_b), .rd_ready(rd_ready_b), .flush(flush_b),
        .data_out(data_out_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .occupancy(occupancy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] mdl_a[4];
    logic [31:0] mdl_b[3];
    logic [31:0] exp_a, exp_b;

    // Output monitors: a transfer seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid_a && out_ready_a) begin
            n_checks++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL sb_a_unexpected: data_out=%h with no read outstanding", data_out_a);
            end else begin
                exp_a = q_a.pop_front();
                if (data_out_a !== exp_a) begin
                    n_fail++;
                    $display("FAIL sb_a_data: got %h expected %h", data_out_a, exp_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid_b && out_ready_b) begin
            n_checks++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL sb_b_unexpected: data_out=%h with no read outstanding", data_out_b);
            end else begin
                exp_b = q_b.pop_front();
                if (data_out_b !== exp_b) begin
                    n_fail++;
                    $display("FAIL sb_b_data: got %h expected %h", data_out_b, exp_b);
                end
            end
        end
    end

    task automatic cyc_a(input logic ld, input int la, input logic [31:0] d, input logic rv,
                         input int ra, input logic ordy, input logic fl,
                         output logic acc, output logic rdy);
        load_a = ld; load_addr_a = la[1:0]; data_in_a = d;
        rd_valid_a = rv; rd_addr_a = ra[1:0]; out_ready_a = ordy; flush_a = fl;
        @(negedge clk);
        rdy = rd_ready_a;
        acc = rv && rd_ready_a;
        if (acc) q_a.push_back((ld && la == ra) ? d : mdl_a[ra]);
        if (ld) mdl_a[la] = d;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input logic ld, input int la, input logic [31:0] d, input logic rv,
                         input int ra, input logic ordy, output logic acc);
        load_b = ld; load_addr_b = la[1:0]; data_in_b = d;
        rd_valid_b = rv; rd_addr_b = ra[1:0]; out_ready_b = ordy; flush_b = 1'b0;
        @(negedge clk);
        acc = rv && rd_ready_b;
        if (acc) q_b.push_back((ra >= 3) ? 32'h0 : ((ld && la == ra) ? d : mdl_b[ra]));
        if (ld && la < 3) mdl_b[la] = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a();
        logic acc, rdy;
        for (int i = 0; i < 20 && q_a.size() != 0; i++) cyc_a(0, 0, 0, 0, 0, 1, 0, acc, rdy);
    endtask

    task automatic drain_b();
        logic acc;
        for (int i = 0; i < 20 && q_b.size() != 0; i++) cyc_b(0, 0, 0, 0, 0, 1, acc);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_checks += 5;
        if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid_a); end
        if (data_out_a !== 32'h0) begin n_fail++; $display("FAIL rst_data_out: got %h expected 0", data_out_a); end
        if (occupancy_a !== 2'd0) begin n_fail++; $display("FAIL rst_occupancy: got %0d expected 0", occupancy_a); end
        if (rd_ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_rd_ready: got %b expected 1", rd_ready_a); end
        if (out_valid_b !== 1'b0) begin n_fail++; $display("FAIL rst_b_out_valid: got %b expected 0", out_valid_b); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic acc, rdy;
        int lat;
        cyc_a(1, 1, 32'hDEADBEEF, 0, 0, 1, 0, acc, rdy);
        cyc_a(0, 0, 0, 1, 1, 1, 0, acc, rdy);
        n_checks++;
        if (acc !== 1'b1) begin n_fail++; $display("FAIL basic_accept: got %b expected 1", acc); end
        lat = 1;
        while (!out_valid_a && lat < 20) begin
            cyc_a(0, 0, 0, 0, 0, 1, 0, acc, rdy);
            lat++;
        end
        n_checks += 2;
        if (lat != 2) begin n_fail++; $display("FAIL basic_latency: got %0d expected 2", lat); end
        if (data_out_a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_data: got %h expected deadbeef", data_out_a); end
        cyc_a(0, 0, 0, 1, 0, 1, 0, acc, rdy);
        cyc_a(0, 0, 0, 1, 2, 1, 0, acc, rdy);
        cyc_a(0, 0, 0, 1, 3, 1, 0, acc, rdy);
        drain_a();
        n_checks++;
        if (q_a.size() != 0) begin n_fail++; $display("FAIL basic_drain: %0d reads outstanding, expected 0", q_a.size()); end
    endtask

    task automatic test_bypass();
        logic acc, rdy;
        cyc_a(1, 2, 32'h12345678, 1, 2, 1, 0, acc, rdy);
        n_checks++;
        if (acc !== 1'b1) begin n_fail++; $display("FAIL bypass_accept: got %b expected 1", acc); end
        cyc_a(1, 2, 32'h0000AAAA, 0, 0, 1, 0, acc, rdy);
        cyc_a(1, 3, 32'h00000055, 1, 1, 1, 0, acc, rdy);
        drain_a();
        cyc_a(0, 0, 0, 1, 2, 1, 0, acc, rdy);
        cyc_a(0, 0, 0, 1, 3, 1, 0, acc, rdy);
        drain_a();
        n_checks++;
        if (q_a.size() != 0) begin n_fail++; $display("FAIL bypass_drain: %0d reads outstanding, expected 0", q_a.size()); end
    endtask

    task automatic test_backpressure();
        logic acc, rdy;
        int ad[5] = '{1, 2, 3, 0, 1};
        int p = 0;
        int cnt;
        cyc_a(1, 0, 32'h0BADF00D, 0, 0, 1, 0, acc, rdy);
        for (int c = 0; c < 5; c++) begin
            cyc_a(0, 0, 0, 1, ad[p], 0, 0, acc, rdy);
            if (acc) p++;
        end
        #1;
        n_checks += 4;
        if (p != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", p); end
        if (rd_ready_a !== 1'b0) begin n_fail++; $display("FAIL bp_rd_ready: got %b expected 0", rd_ready_a); end
        if (occupancy_a !== 2'd2) begin n_fail++; $display("FAIL bp_occupancy: got %0d expected 2", occupancy_a); end
        if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b expected 1", out_valid_a); end
        cyc_a(0, 0, 0, 1, ad[p], 1, 0, acc, rdy);
        n_checks++;
        if (rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", rdy); end
        if (acc) p++;
        cnt = 1;
        while (p < 5 && cnt < 20) begin
            cyc_a(0, 0, 0, 1, ad[p], 1, 0, acc, rdy);
            if (acc) p++;
            cnt++;
        end
        n_checks++;
        if (cnt != 3) begin n_fail++; $display("FAIL bp_resume_cycles: got %0d expected 3", cnt); end
        drain_a();
        n_checks++;
        if (q_a.size() != 0) begin n_fail++; $display("FAIL bp_drain: %0d reads outstanding, expected 0", q_a.size()); end
    endtask

    task automatic test_flush();
        logic acc, rdy;
        cyc_a(0, 0, 0, 1, 1, 0, 0, acc, rdy);
        cyc_a(0, 0, 0, 1, 2, 0, 0, acc, rdy);
        cyc_a(0, 0, 0, 1, 3, 0, 1, acc, rdy);
        n_checks += 3;
        if (rdy !== 1'b0) begin n_fail++; $display("FAIL flush_rd_ready: got %b expected 0", rdy); end
        if (occupancy_a !== 2'd0) begin n_fail++; $display("FAIL flush_occupancy: got %0d expected 0", occupancy_a); end
        if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid_a); end
        q_a.delete();
        cyc_a(0, 0, 0, 1, 3, 0, 0, acc, rdy);
        cyc_a(0, 0, 0, 1, 0, 0, 0, acc, rdy);
        cyc_a(0, 0, 0, 0, 0, 1, 1, acc, rdy);
        n_checks++;
        if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL flush_xfer_out_valid: got %b expected 0", out_valid_a); end
        q_a.delete();
        for (int r = 0; r < 4; r++) cyc_a(0, 0, 0, 1, r, 1, 0, acc, rdy);
        drain_a();
        n_checks++;
        if (q_a.size() != 0) begin n_fail++; $display("FAIL flush_drain: %0d reads outstanding, expected 0", q_a.size()); end
    endtask

    task automatic test_reset_async();
        logic acc, rdy;
        cyc_a(0, 0, 0, 1, 1, 0, 0, acc, rdy);
        cyc_a(0, 0, 0, 1, 2, 0, 0, acc, rdy);
        #2;
        reset = 1'b1;
        rd_valid_a = 1'b0;
        #1;
        n_checks += 3;
        if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid: got %b expected 0", out_valid_a); end
        if (data_out_a !== 32'h0) begin n_fail++; $display("FAIL arst_data_out: got %h expected 0", data_out_a); end
        if (occupancy_a !== 2'd0) begin n_fail++; $display("FAIL arst_occupancy: got %0d expected 0", occupancy_a); end
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        q_a.delete();
        q_b.delete();
        for (int r = 0; r < 4; r++) mdl_a[r] = 32'h0;
        for (int r = 0; r < 3; r++) mdl_b[r] = 32'h0;
        for (int r = 0; r < 4; r++) cyc_a(0, 0, 0, 1, r, 1, 0, acc, rdy);
        drain_a();
        n_checks++;
        if (q_a.size() != 0) begin n_fail++; $display("FAIL arst_drain: %0d reads outstanding, expected 0", q_a.size()); end
    endtask

    task automatic test_small_inst();
        logic acc;
        int lat;
        cyc_b(1, 2, 32'h00000022, 0, 0, 1, acc);
        cyc_b(1, 3, 32'h00000077, 0, 0, 1, acc);
        cyc_b(0, 0, 0, 1, 3, 1, acc);
        n_checks++;
        if (acc !== 1'b1) begin n_fail++; $display("FAIL small_accept: got %b expected 1", acc); end
        lat = 1;
        while (!out_valid_b && lat < 20) begin
            cyc_b(0, 0, 0, 0, 0, 1, acc);
            lat++;
        end
        n_checks += 2;
        if (lat != 4) begin n_fail++; $display("FAIL small_latency: got %0d expected 4", lat); end
        if (data_out_b !== 32'h0) begin n_fail++; $display("FAIL small_oob_data: got %h expected 0", data_out_b); end
        cyc_b(1, 3, 32'h00000099, 1, 3, 1, acc);
        cyc_b(0, 0, 0, 1, 2, 1, acc);
        cyc_b(0, 0, 0, 1, 0, 1, acc);
        drain_b();
        n_checks++;
        if (q_b.size() != 0) begin n_fail++; $display("FAIL small_drain: %0d reads outstanding, expected 0", q_b.size()); end
    endtask

    initial begin
        load_a = 0; load_addr_a = 0; data_in_a = 0; rd_valid_a = 0; rd_addr_a = 0;
        out_ready_a = 1; flush_a = 0;
        load_b = 0; load_addr_b = 0; data_in_b = 0; rd_valid_b = 0; rd_addr_b = 0;
        out_ready_b = 1; flush_b = 0;
        for (int r = 0; r < 4; r++) mdl_a[r] = 32'h0;
        for (int r = 0; r < 3; r++) mdl_b[r] = 32'h0;

        test_reset();
        test_basic();
        test_bypass();
        test_backpressure();
        test_flush();
        test_reset_async();
        test_small_inst();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_bank_pipe.md
# reg_bank_pipe

Parametrised multi-register holding bank with a PIPE_DEPTH-stage, bubble-collapsing read pipeline and a valid/ready output handshake. It generalises the single load-and-delay operand register: NUM_REGS addressable registers replace the one register, the fixed two-stage delay becomes configurable, and it adds backpressure, flush and write-first bypass. It sits between the control/load path and the execution datapath as the operand source.

## Interface
- DATA_WIDTH, 32, width of each register and of the data path
- NUM_REGS, 4, number of registers, ≥1; ADDR_WIDTH = max(1, $clog2(NUM_REGS))
- PIPE_DEPTH, 2, read pipeline stages, ≥1
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- load  in  1  write enable
- load_addr  in  ADDR_WIDTH  write address
- data_in  in  DATA_WIDTH  write data
- rd_valid  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_ready  out  1  stage 0 accepts a request this cycle
- flush  in  1  synchronous discard of all in-flight reads
- data_out  out  DATA_WIDTH  last-stage data
- out_valid  out  1  last stage holds a valid read
- out_ready  in  1  consumer accepts data_out
- occupancy  out  $clog2(PIPE_DEPTH+1)  number of valid stages

## Operation
- Reset: all registers, stage data and valid bits go to 0, so data_out = 0, out_valid = 0 and occupancy = 0. rd_ready is 1 while flush is 0. Requests are ignored while reset is asserted. Reset mid-operation drops all in-flight reads.
- Write: a write is performed on every edge with load = 1. It is never blocked by stalls or flush. A load_addr ≥ NUM_REGS is ignored.
- Read acceptance: a read is accepted when rd_valid && rd_ready.
  - Stage 0 captures {valid=1, data}. data = regs[rd_addr], or data_in if load && load_addr == rd_addr in the same cycle (write-first).
  - A rd_addr ≥ NUM_REGS returns 0.
- Snapshot rule: data in flight is a snapshot. Later writes do not alter it.
- Stage advance: stage i accepts when !v[i] or stage i+1 accepts. The last stage accepts when !v[last] or out_ready. An accepting stage loads from its predecessor; a non-accepting stage holds. Bubbles therefore collapse under backpressure.
- rd_ready = stage-0 accept && !flush.
- Output: data_out and out_valid are driven directly from the last stage. A transfer occurs on out_valid && out_ready. With out_valid = 0, data_out holds its last value and is don't-care.
- flush: at the next edge all valid bits clear and any concurrent request is dropped; register contents are unaffected.
- occupancy: combinational popcount of the stage valid bits.

## Timing
- Latency: a request accepted at the edge ending cycle C gives out_valid = 1 in cycle C+PIPE_DEPTH, provided no stall. PIPE_DEPTH=2 is the default two-cycle delay.
- Throughput: one read per cycle while out_ready = 1.
- Capacity: with out_ready held at 0, exactly PIPE_DEPTH requests are accepted, then rd_ready = 0. After out_ready rises, rd_ready returns to 1 in the same cycle, because the chain accepts combinationally.
- Simultaneous write and read to one address: returns the new data. Simultaneous write and read to different addresses: independent.
- flush with out_valid = 1 and out_ready = 1: that transfer completes in the same cycle; out_valid = 0 in the next cycle.
- No combinational path from data_in to data_out. The out_ready → rd_ready path is combinational; its depth is PIPE_DEPTH.

## Structure
- Package reg_bank_pkg:
  - default parameter constants
  - function addr_w(n) returning max(1, $clog2(n))
  - function in_range(addr, n)
- Sub-module pipe_stage (one valid/data stage):
  - ports: up_valid, up_data, down_accept, flush, up_accept, v, data
  - instantiated PIPE_DEPTH times in a generate loop
- Top level holds the register array, write/bypass logic and occupancy.

## Test plan
- Reset, then write regs[1]=0xDEADBEEF, read addr 1 with out_ready=1 → out_valid=1 with 0xDEADBEEF exactly 2 cycles after acceptance; reads of never-written addresses → 0.
- Same-cycle load addr 2 = 0x12345678 and read addr 2 → returns 0x12345678. Write 0xAAAA to addr 2 the cycle after acceptance → in-flight value is still 0x12345678.
- out_ready=0 while issuing 5 back-to-back reads → 2 accepted, rd_ready=0, occupancy=2. Release out_ready → both delivered in order, then the remaining 3 are accepted in consecutive cycles.
- Fill the pipeline, assert flush for 1 cycle with a concurrent rd_valid → occupancy=0 and out_valid=0 next cycle, request dropped, register contents unchanged on readback.
- Assert reset asynchronously mid-stream (between edges) → out_valid, data_out and occupancy are 0 immediately, all registers read back 0.
- NUM_REGS=3, PIPE_DEPTH=4 instance: write to addr 3 is ignored, read of addr 3 → 0, latency = 4 cycles.
